// File: rtl/regfile_arbiter.sv
// regfile_arbiter: two-port access controller for the four-entry vector
// register file (A1..A4).
//
// Ports:
//   clk, rst_n            rising-edge clock, synchronous active-low reset
//   reqN_valid/_ready     request handshake (ready is a combinational grant)
//   reqN_we/_idx/_lock    write/read select, target register, keep ownership
//   rspN_valid            dataOut holds port N's read result this cycle
//   rf_write, rf_read     one-hot write/read strobes to the register file
//   rf_wsel               dataIn source select (0=port 0, 1=port 1)
//   busy                  strobe or response in flight, or a lock is held
//
// Build option: RF_ARB_FIXED_PRIO_EN selects fixed priority (port 0 wins)
// instead of round-robin for idle-state arbitration.
module regfile_arbiter #(
  parameter int unsigned NUM_REGS = 4,
  parameter int unsigned IDX_W    = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic                req0_we,
  input  logic [IDX_W-1:0]    req0_idx,
  input  logic                req0_lock,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic                req1_we,
  input  logic [IDX_W-1:0]    req1_idx,
  input  logic                req1_lock,
  output logic                rsp0_valid,
  output logic                rsp1_valid,
  output logic [NUM_REGS-1:0] rf_write,
  output logic [NUM_REGS-1:0] rf_read,
  output logic                rf_wsel,
  output logic                busy
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_OWN0 = 2'b01;
  localparam logic [1:0] ST_OWN1 = 2'b10;

  logic [1:0]          state_q, state_d;
  logic [NUM_REGS-1:0] write_q, write_d;
  logic [NUM_REGS-1:0] read_q, read_d;
  logic                wsel_q, wsel_d;
  logic                tag_vld_q, tag_vld_d;
  logic                tag_q, tag_d;
  logic                rsp0_q, rsp0_d;
  logic                rsp1_q, rsp1_d;
  logic                busy_q, busy_d;
`ifndef RF_ARB_FIXED_PRIO_EN
  logic                last_q, last_d;
`endif

  logic                gnt0, gnt1, acc, sel, sel_we, sel_lock;
  logic [IDX_W-1:0]    sel_idx;

  // Grant: owner-only while locked, otherwise arbitrate between valid ports.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n) begin
      case (state_q)
        ST_IDLE: begin
          if (req0_valid && req1_valid) begin
`ifdef RF_ARB_FIXED_PRIO_EN
            gnt0 = 1'b1;
`else
            // Favour the port that was not granted last.
            gnt0 = last_q;
            gnt1 = !last_q;
`endif
          end else begin
            gnt0 = req0_valid;
            gnt1 = req1_valid;
          end
        end
        ST_OWN0: gnt0 = req0_valid;
        ST_OWN1: gnt1 = req1_valid;
        default: ;
      endcase
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  assign acc      = gnt0 || gnt1;
  assign sel      = gnt1;
  assign sel_we   = sel ? req1_we   : req0_we;
  assign sel_lock = sel ? req1_lock : req0_lock;
  assign sel_idx  = sel ? req1_idx  : req0_idx;

  // Next state: ownership FSM, one-cycle strobes, 2-deep read tag pipeline.
  always_comb begin
    state_d   = state_q;
    write_d   = '0;
    read_d    = '0;
    wsel_d    = 1'b0;
    tag_vld_d = 1'b0;
    tag_d     = 1'b0;
`ifndef RF_ARB_FIXED_PRIO_EN
    last_d    = last_q;
`endif
    if (acc) begin
      if (sel_we) write_d = NUM_REGS'(1) << sel_idx;
      else        read_d  = NUM_REGS'(1) << sel_idx;
      wsel_d    = sel;
      tag_vld_d = !sel_we;
      tag_d     = sel;
      state_d   = sel_lock ? (sel ? ST_OWN1 : ST_OWN0) : ST_IDLE;
`ifndef RF_ARB_FIXED_PRIO_EN
      last_d    = sel;
`endif
    end
    // Response lands the cycle after the read strobe, when dataOut is stable.
    rsp0_d = tag_vld_q && !tag_q;
    rsp1_d = tag_vld_q && tag_q;
    busy_d = (|write_d) || (|read_d) || tag_vld_d || rsp0_d || rsp1_d ||
             (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      write_q   <= '0;
      read_q    <= '0;
      wsel_q    <= 1'b0;
      tag_vld_q <= 1'b0;
      tag_q     <= 1'b0;
      rsp0_q    <= 1'b0;
      rsp1_q    <= 1'b0;
      busy_q    <= 1'b0;
`ifndef RF_ARB_FIXED_PRIO_EN
      last_q    <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      write_q   <= write_d;
      read_q    <= read_d;
      wsel_q    <= wsel_d;
      tag_vld_q <= tag_vld_d;
      tag_q     <= tag_d;
      rsp0_q    <= rsp0_d;
      rsp1_q    <= rsp1_d;
      busy_q    <= busy_d;
`ifndef RF_ARB_FIXED_PRIO_EN
      last_q    <= last_d;
`endif
    end
  end

  assign rf_write   = write_q;
  assign rf_read    = read_q;
  assign rf_wsel    = wsel_q;
  assign rsp0_valid = rsp0_q;
  assign rsp1_valid = rsp1_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Testbench for regfile_arbiter: transaction-level model scheduling the
// expected strobes/responses by latency, plus a lane-0 register file model
// driven by the DUT's strobes to check end-to-end read data.
module tb_regfile_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       v0, rdy0, we0, lk0, v1, rdy1, we1, lk1;
  logic [1:0] idx0, idx1;
  logic [15:0] d0, d1;
  logic       rsp0, rsp1, wsel, busy;
  logic [3:0] rfw, rfr;

  always #5 clk = ~clk;

  regfile_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v0), .req0_ready(rdy0), .req0_we(we0), .req0_idx(idx0), .req0_lock(lk0),
    .req1_valid(v1), .req1_ready(rdy1), .req1_we(we1), .req1_idx(idx1), .req1_lock(lk1),
    .rsp0_valid(rsp0), .rsp1_valid(rsp1), .rf_write(rfw), .rf_read(rfr),
    .rf_wsel(wsel), .busy(busy)
  );

  int vectors = 0;
  int errs    = 0;
  int cyc     = 0;
  bit outs_known = 1'b0;

  // Model state: owner (-1 none), last granted port, expectation ring by cycle.
  int         own  = -1;
  int         last = 1;
  logic [3:0] e_wr[4], e_rd[4];
  logic       e_wsel[4], e_rsp0[4], e_rsp1[4];
  logic [15:0] e_dat[4], e_wd[4];
  logic [15:0] mem[4];

  // Register file stand-in driven purely by DUT strobes.
  logic [15:0] rf[4];
  logic [15:0] hold0 = '0, hold1 = '0, bdout = '0;

  // Samples from the most recent tick.
  logic       s_rdy0, s_rdy1, s_wsel, s_rsp0, s_rsp1, s_busy;
  logic [3:0] s_wr, s_rd;
  logic [15:0] s_dout;
  logic       acc0 = 1'b0, acc1 = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic clr_slot(input int s);
    e_wr[s] = '0; e_rd[s] = '0; e_wsel[s] = 1'b0;
    e_rsp0[s] = 1'b0; e_rsp1[s] = 1'b0; e_dat[s] = '0; e_wd[s] = '0;
  endtask

  // One clock cycle: inputs already driven; sample, compare, advance model.
  task automatic tick();
    logic g0, g1, p, pwe, plk, known;
    logic [1:0] pidx;
    logic [15:0] pd;
    int sl, nx, n2;
    #1;
    sl = cyc % 4; nx = (cyc + 1) % 4; n2 = (cyc + 2) % 4;
    g0 = 1'b0; g1 = 1'b0;
    if (rst_n) begin
      if (own == 0)      g0 = v0;
      else if (own == 1) g1 = v1;
      else if (v0 && v1) begin
`ifdef RF_ARB_FIXED_PRIO_EN
        g0 = 1'b1;
`else
        if (last == 1) g0 = 1'b1; else g1 = 1'b1;
`endif
      end else begin
        g0 = v0; g1 = v1;
      end
    end
    s_rdy0 = rdy0; s_rdy1 = rdy1; s_wr = rfw; s_rd = rfr; s_wsel = wsel;
    s_rsp0 = rsp0; s_rsp1 = rsp1; s_busy = busy; s_dout = bdout;
    known = outs_known;
    chk("req0_ready", rdy0, g0);
    chk("req1_ready", rdy1, g1);
    if (known) begin
      chk("rf_write", rfw, e_wr[sl]);
      chk("rf_read", rfr, e_rd[sl]);
      chk("rf_wsel", wsel, e_wsel[sl]);
      chk("rsp0_valid", rsp0, e_rsp0[sl]);
      chk("rsp1_valid", rsp1, e_rsp1[sl]);
      chk("busy", busy, ((e_wr[sl] | e_rd[sl]) != 0) || e_rsp0[sl] || e_rsp1[sl] || own != -1);
      if (e_rsp0[sl] || e_rsp1[sl]) chk("dataOut", bdout, e_dat[sl]);
    end
    // A write strobe that survived to this cycle commits now.
    for (int k = 0; k < 4; k++) if (e_wr[sl][k]) mem[k] = e_wd[sl];
    clr_slot(sl);
    if (!rst_n) begin
      clr_slot(nx); clr_slot(n2);
      own = -1; last = 1;
    end else if (g0 || g1) begin
      p = g1;
      pwe = p ? we1 : we0; pidx = p ? idx1 : idx0;
      plk = p ? lk1 : lk0; pd = p ? d1 : d0;
      if (pwe) begin
        e_wr[nx] = 4'(1 << pidx); e_wd[nx] = pd;
      end else begin
        e_rd[nx] = 4'(1 << pidx);
        if (p) e_rsp1[n2] = 1'b1; else e_rsp0[n2] = 1'b1;
        e_dat[n2] = mem[pidx];
      end
      e_wsel[nx] = p;
      own  = plk ? int'(p) : -1;
      last = int'(p);
    end
    acc0 = g0; acc1 = g1;
    @(posedge clk);
    if (known) begin
      for (int k = 0; k < 4; k++) begin
        if (s_wr[k]) rf[k] = s_wsel ? hold1 : hold0;
        if (s_rd[k]) bdout = rf[k];
      end
    end
    if (g0) hold0 = d0;
    if (g1) hold1 = d1;
    if (!rst_n) outs_known = 1'b1;
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    v0 = 1'b0; v1 = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      clr_slot(k); mem[k] = '0; rf[k] = '0;
    end
    rst_n = 1'b0;
    v0 = 1'b1; we0 = 1'b0; idx0 = 2'd0; lk0 = 1'b0; d0 = '0;
    v1 = 1'b1; we1 = 1'b0; idx1 = 2'd3; lk1 = 1'b0; d1 = '0;

    // Reset with both requesters valid.
    tick();
    tick();
    chk("rst_ready0", s_rdy0, 1'b0);
    chk("rst_ready1", s_rdy1, 1'b0);
    chk("rst_rf", {s_wr, s_rd}, 8'h00);
    chk("rst_busy", s_busy, 1'b0);

    // Contention: reads idx0 (port 0) vs idx3 (port 1).
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
`ifdef RF_ARB_FIXED_PRIO_EN
      chk("cont_ready0", s_rdy0, 1'b1);
      if (i >= 1) chk("cont_rf_read", s_rd, 4'b0001);
`else
      chk("cont_ready0", s_rdy0, (i % 2) == 0);
      if (i >= 1) chk("cont_rf_read", s_rd, (i % 2) == 1 ? 4'b0001 : 4'b1000);
      if (i >= 2) chk("cont_rsp0", s_rsp0, (i % 2) == 0);
`endif
    end
    idle(3);

    // Single write from port 1 to idx 2.
    v1 = 1'b1; we1 = 1'b1; idx1 = 2'd2; lk1 = 1'b0; d1 = 16'hABCD;
    tick();
    chk("wr_ready1", s_rdy1, 1'b1);
    v1 = 1'b0;
    tick();
    chk("wr_strobe", s_wr, 4'b0100);
    chk("wr_wsel", s_wsel, 1'b1);
    tick();
    chk("wr_strobe_gone", {s_wr, s_wsel, s_rsp1}, 6'b0);
    idle(2);

    // Lock: port 1 issues lock=1,1,0 while port 0 waits.
    v1 = 1'b1; we1 = 1'b0; idx1 = 2'd0; lk1 = 1'b1;
    tick();
    chk("lk_ready1", s_rdy1, 1'b1);
    v0 = 1'b1; we0 = 1'b0; idx0 = 2'd3; lk0 = 1'b0;
    idx1 = 2'd1; lk1 = 1'b1;
    tick();
    chk("lk_ready0_a", s_rdy0, 1'b0);
    chk("lk_busy", s_busy, 1'b1);
    idx1 = 2'd2; lk1 = 1'b0;
    tick();
    chk("lk_ready0_b", s_rdy0, 1'b0);
    chk("lk_release", s_rdy1, 1'b1);
    v1 = 1'b0;
    tick();
    chk("lk_ready0_after", s_rdy0, 1'b1);
    idle(3);

    // Write then read of idx 1 with no stall.
    v0 = 1'b1; we0 = 1'b1; idx0 = 2'd1; d0 = 16'h7FFF; lk0 = 1'b0;
    tick();
    chk("raw_ready_wr", s_rdy0, 1'b1);
    we0 = 1'b0;
    tick();
    chk("raw_ready_rd", s_rdy0, 1'b1);
    v0 = 1'b0;
    tick();
    tick();
    chk("raw_rsp0", s_rsp0, 1'b1);
    chk("raw_data", s_dout, 16'h7FFF);
    idle(2);

    // Reset while a read is in flight.
    v0 = 1'b1; we0 = 1'b0; idx0 = 2'd2;
    tick();
    v0 = 1'b0; rst_n = 1'b0;
    tick();
    chk("mid_strobe", s_rd, 4'b0100);
    rst_n = 1'b1;
    tick();
    chk("mid_no_rsp", s_rsp0, 1'b0);
    chk("mid_busy", s_busy, 1'b0);
    idle(2);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 63) != 0);
      if (!v0 || acc0) begin
        v0 = 1'($urandom_range(0, 1)); we0 = 1'($urandom_range(0, 1));
        idx0 = 2'($urandom_range(0, 3)); lk0 = ($urandom_range(0, 3) == 0);
        d0 = 16'($urandom);
      end
      if (!v1 || acc1) begin
        v1 = 1'($urandom_range(0, 1)); we1 = 1'($urandom_range(0, 1));
        idx1 = 2'($urandom_range(0, 3)); lk1 = ($urandom_range(0, 3) == 0);
        d1 = 16'($urandom);
      end
      tick();
    end
    rst_n = 1'b1;
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/regfile_arbiter.md
# regfile_arbiter

Access controller for the four-entry vector register file (A1..A4, 32 x 16-bit lanes each). It arbitrates two requesters, the memory/load-store port (port 0) and the vector ALU port (port 1), onto the register file's one-hot write1..4 / read1..4 strobes. It also drives the dataIn source-select and returns a per-port read-data-valid pulse aligned to when dataOut is stable. It supports locked multi-transaction ownership for atomic read-modify-write sequences.

## Interface
- NUM_REGS, 4, number of vector registers; fixed at 4 to match the register file
- IDX_W, 2, register index width, $clog2(NUM_REGS)
- clk  in  1  rising-edge clock shared with the register file
- rst_n  in  1  synchronous, active-low reset
- reqN_valid  in  1  (N=0,1) request present
- reqN_ready  out  1  request accepted this cycle (combinational grant)
- reqN_we  in  1  1=write dataIn into register, 0=read register to dataOut
- reqN_idx  in  IDX_W  target register, 0..3 → A1..A4
- reqN_lock  in  1  keep ownership after this transaction
- rspN_valid  out  1  register-file dataOut holds port N's read result this cycle
- rf_write  out  NUM_REGS  one-hot, drives write1..write4 (bit k → write(k+1))
- rf_read  out  NUM_REGS  one-hot, drives read1..read4
- rf_wsel  out  1  dataIn mux select: 0=port 0 data, 1=port 1 data
- busy  out  1  a strobe or response is in flight, or a lock is held

## Operation
- Handshake: transfer on reqN_valid && reqN_ready at a rising edge. Requester holds we/idx/lock/data stable while valid && !ready; valid must not drop before acceptance.
- At most one grant per cycle. rf_write | rf_read is zero or one-hot, never both.
- FSM states:
  - IDLE: normal arbitration; both ports eligible.
  - OWN0: only port 0 eligible; req1_ready=0.
  - OWN1: only port 1 eligible; req0_ready=0.
- FSM transitions:
  - IDLE → OWNn on an accepted port-n transaction with lock=1.
  - OWNn → IDLE on an accepted port-n transaction with lock=0.
  - OWNn holds indefinitely while port n is idle; there is no timeout.
- Arbitration in IDLE:
  - One valid requester is granted.
  - Both valid: round-robin. Grant the port not granted last; last-grant pointer updates only on an accepted transfer.
  - The pointer after reset favours port 0.
- Issue: an accepted request registers rf_write[idx] (we=1) or rf_read[idx] (we=0), plus rf_wsel=granting port, for exactly one cycle.
- Read response: a one-cycle rspN_valid for the originating port, tracked by a 2-deep tag pipeline.
- Back-to-back write then read of the same index needs no stall. The read strobe is one cycle after the write strobe, so the register file returns the new value.
- Reset (rst_n=0 at an edge):
  - rf_write=0, rf_read=0, rf_wsel=0, rsp0_valid=rsp1_valid=0, busy=0.
  - FSM → IDLE, pointer → port 0 preferred.
  - In-flight strobes and responses are discarded. A read accepted before reset never produces a response.
  - reqN_ready is 0 while rst_n=0.

## Timing
- Cycle T: handshake (combinational ready).
- T+1: rf_write/rf_read/rf_wsel asserted (registered); the register file samples at the end of T+1.
- T+2: rspN_valid=1 for a read; dataOut valid from T+2 until the next read strobe.
- Throughput: one transaction per cycle. Read latency: 2 cycles from acceptance to rsp.
- Lock release: a lock=0 transfer at T allows the other port ready in T+1.
- busy = any strobe asserted, or pending response, or FSM≠IDLE (registered).

## Configuration
- RF_ARB_FIXED_PRIO_EN defined: IDLE arbitration is fixed priority. Port 0 always wins a conflict, and the round-robin pointer is removed. Lock behaviour is unchanged.
- RF_ARB_FIXED_PRIO_EN undefined (default): round-robin as above.

## Test plan
- Reset:
  - Stimulus: rst_n=0 for 2 cycles with both valid.
  - Required response: ready=0, rf_write=rf_read=0, rsp*=0, busy=0. First cycle after release with both valid → req0_ready=1.
- Single write:
  - Stimulus: port 1 we=1 idx=2 accepted at T.
  - Required response: rf_write=4'b0100 and rf_wsel=1 in T+1 only; no rsp.
- Contention:
  - Stimulus: both ports valid continuously for reads idx=0 and idx=3.
  - Required response: grants alternate 0,1,0,1. rf_read alternates 0001/1000. rsp0/rsp1 alternate starting T+2.
- Lock:
  - Stimulus: port 1 issues three transactions (lock=1,1,0) while port 0 is valid throughout.
  - Required response: req0_ready=0 until the lock=0 transfer at T; req0_ready=1 in T+1.
- RAW:
  - Stimulus: port 0 writes idx=1 with lane 0=16'sh7FFF at T, then reads idx=1 at T+1.
  - Required response: rsp0_valid at T+3 with dataOut[0]=16'sh7FFF.
- Reset mid-read:
  - Stimulus: read accepted at T, rst_n=0 at the edge ending T+1.
  - Required response: no rsp at T+2; FSM IDLE.
  - With RF_ARB_FIXED_PRIO_EN: the contention test grants port 0 every cycle.
